ins_loader_enc: RTL
===================

Name: ins_loader_enc

Overview:
- Instruction encoder and loader: the encoding end of the datapath's RV32I instruction decode (opcode class → control, funct3/funct7 → ALU op).
- Accepts field descriptors over a valid/ready stream and encodes each one into a 32-bit instruction word.
- Writes the words to sequential instruction-memory addresses through a valid/ready write port.
- When the program is loaded, outputs the entry point and pulses the interrupt that redirects the PC to it.

Parameters:
- LEN_W, 16, width of program length and word counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  32  byte address of the first instruction; bits [1:0] forced to 0.
- len  in  LEN_W  number of descriptors to consume.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_cls  in  3  descriptor class: 0 R, 1 I(ALU), 2 LW, 3 S, 4 B, 5 J, 6/7 reserved.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3; ignored for LW (forced 010) and J.
- in_f7b5  in  1  funct7 bit 5 (ins[30]); R class only.
- in_imm  in  21  signed immediate; low 12/13/21 bits used per class.
- mem_valid  out  1  write request.
- mem_ready  in  1  memory accepts the write when mem_valid && mem_ready.
- mem_addr  out  32  write address.
- mem_wdata  out  32  encoded instruction.
- entry_point  out  32  latched base_addr.
- int_out  out  1  one-cycle pulse after the last write.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on an illegal descriptor (feature only).

Behaviour:
- Reset values: in_ready, mem_valid, int_out, busy and err are 0. mem_addr, mem_wdata and entry_point are 0. FSM is in IDLE. Reset mid-load drops any in-flight word; no further writes occur.
- Opcodes: R 0110011, I 0010011, LW 0000011, S 0100011, B 1100011, J 1101111.
- Immediate placement:
  - I/LW: imm[11:0] → [31:20].
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - B: imm[12|10:5] → [31:25], imm[4:1|11] → [11:7].
  - J: imm[20|10:1|11|19:12] → [31:12].
- Field placement:
  - rd → [11:7] for R/I/LW/J.
  - rs1 → [19:15] and funct3 → [14:12] for all classes except J.
  - rs2 → [24:20] for R/S/B.
  - R: [31:25] = {1'b0, f7b5, 5'b0}.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: on start, latch base_addr, len and entry_point, and clear counters. If len==0, go to DONE; otherwise go to LOAD.
  - LOAD: in_ready = (acc_cnt < len_q) && (!mem_valid || mem_ready). Each accept registers the encoded word into the output stage, so mem_valid/mem_wdata appear the cycle after acceptance (latency 1). Each accept increments acc_cnt. When acc_cnt reaches len_q, go to DRAIN.
  - DRAIN: wait until the output stage is empty (no mem_valid, or final handshake this cycle), then go to DONE.
  - DONE: int_out=1 for exactly one cycle, then go to IDLE.
- Addressing: mem_addr = base_q + 4*wr_cnt. wr_cnt increments on each write handshake. Address arithmetic wraps modulo 2^32.
- Back-to-back accepts:
  - Full throughput of 1 word/cycle while mem_ready=1.
  - When mem_ready=0, mem_valid, mem_addr and mem_wdata hold stable and in_ready=0.
- start while busy is ignored. A start in the same cycle as DONE's int_out is ignored.

Optional Feature:
- Macro: ENC_ILLEGAL_CHK_EN.
- With the macro, a descriptor is illegal if in_cls is 6/7, or if in_cls is B/J with in_imm[0]=1. An illegal descriptor is:
  - consumed (counts toward len);
  - not written, so wr_cnt does not advance;
  - reported by err pulsing 1 cycle after acceptance.
- Without the macro, err is tied 0. Class 6/7 encodes as NOP 0x00000013 and in_imm[0] is dropped for B/J.

Decomposition:
- Shared package enc_pkg holds:
  - class codes CLS_R..CLS_J;
  - 7-bit opcode constants;
  - FUNCT3_LW = 3'b010;
  - NOP_WORD = 32'h00000013;
  - FSM state enum.
- One combinational sub-module, ins_enc_word (fields → 32-bit word, plus an illegal flag), is instantiated once ahead of the output register.

Test Plan:
- base=0x100, len=1; R rd=3 rs1=1 rs2=2 f3=0 f7b5=0, mem_ready=1 → one write addr 0x100 data 0x002081B3; int_out pulses 2 cycles later; entry_point=0x100.
- len=3: LW rd=5 rs1=2 imm=8; B rs1=1 rs2=2 f3=0 imm=8; R f7b5=1 rd=3 rs1=1 rs2=2 → writes 0x00812283@0x100, 0x00208463@0x104, 0x402081B3@0x108, one per cycle.
- Same stream with mem_ready low for 3 cycles on the 2nd word → addr/data held stable, in_ready=0, no word lost or duplicated, order preserved.
- start with len=0 → no mem_valid; int_out pulses; busy returns 0.
- rst_n asserted mid-load after 1 of 3 writes → outputs at reset values immediately; a new start reloads from its own base with no stale write.
- ENC_ILLEGAL_CHK_EN: descriptor cls=6 between two valid ones (len=3) → err pulses once; two writes at 0x100 and 0x104; int_out after drain. Without the macro, the middle write is 0x00000013.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants for the RV32I instruction encoder/loader: class codes, opcodes,
// fixed words and the loader FSM state type.
package enc_pkg;

   localparam logic [2:0] CLS_R  = 3'd0;
   localparam logic [2:0] CLS_I  = 3'd1;
   localparam logic [2:0] CLS_LW = 3'd2;
   localparam logic [2:0] CLS_S  = 3'd3;
   localparam logic [2:0] CLS_B  = 3'd4;
   localparam logic [2:0] CLS_J  = 3'd5;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;

   localparam logic [2:0]  FUNCT3_LW = 3'b010;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ins_enc_word.sv
// Combinational field-to-word encoder for one RV32I descriptor.
// ENC_ILLEGAL_CHK_EN enables the illegal-descriptor flag; otherwise it is tied 0.
module ins_enc_word
   import enc_pkg::*;
(
   input  logic [2:0]  cls,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        f7b5,
   input  logic [20:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word = NOP_WORD;
      case (cls)
         CLS_R:   word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
         CLS_I:   word = {imm[11:0], rs1, funct3, rd, OP_I};
         CLS_LW:  word = {imm[11:0], rs1, FUNCT3_LW, rd, OP_LW};
         CLS_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
         CLS_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
         CLS_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
         default: word = NOP_WORD;
      endcase
   end

`ifdef ENC_ILLEGAL_CHK_EN
   // Branch/jump targets must be halfword aligned; classes 6/7 are unassigned.
   always_comb begin
      illegal = 1'b0;
      if (cls > CLS_J)
         illegal = 1'b1;
      else if ((cls == CLS_B || cls == CLS_J) && imm[0])
         illegal = 1'b1;
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/ins_loader_enc.sv
// Instruction loader: encodes descriptors, writes them to sequential addresses,
// then pulses int_out with the entry point. Optional macro: ENC_ILLEGAL_CHK_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; latches base/len/entry point
// ST_LOAD  | accepting descriptors until len have been consumed
// ST_DRAIN | waiting for the last word to leave the output stage
// ST_DONE  | int_out high for one cycle, then back to idle
module ins_loader_enc
   import enc_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_cls,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic             in_f7b5,
   input  logic [20:0]      in_imm,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [31:0]      entry_point,
   output logic             int_out,
   output logic             busy,
   output logic             err
);

   state_t           state, state_nxt;
   logic [31:0]      base_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] acc_cnt;
   logic [LEN_W-1:0] wr_cnt;
   logic [31:0]      enc_word;
   logic             enc_illegal;
   logic             accept;
   logic             wr_hs;
   logic             last_acc;

   ins_enc_word u_enc (
      .cls     (in_cls),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .funct3  (in_funct3),
      .f7b5    (in_f7b5),
      .imm     (in_imm),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign accept   = in_valid && in_ready;
   assign wr_hs    = mem_valid && mem_ready;
   assign last_acc = accept && ((acc_cnt + LEN_W'(1)) == len_q);
   assign mem_addr = base_q + (32'(wr_cnt) << 2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start)
               state_nxt = (len == '0) ? ST_DONE : ST_LOAD;
         end
         ST_LOAD: begin
            if (last_acc)
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!mem_valid || mem_ready)
               state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      int_out  = 1'b0;
      busy     = (state != ST_IDLE);
      case (state)
         ST_LOAD: in_ready = (acc_cnt < len_q) && (!mem_valid || mem_ready);
         ST_DONE: int_out  = 1'b1;
         default: ;
      endcase
   end

   // Single output register; an accept and a write handshake may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q      <= '0;
         entry_point <= '0;
         len_q       <= '0;
         acc_cnt     <= '0;
         wr_cnt      <= '0;
         mem_valid   <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            base_q      <= {base_addr[31:2], 2'b00};
            entry_point <= {base_addr[31:2], 2'b00};
            len_q       <= len;
            acc_cnt     <= '0;
            wr_cnt      <= '0;
         end else begin
            if (accept)
               acc_cnt <= acc_cnt + LEN_W'(1);
            if (wr_hs)
               wr_cnt <= wr_cnt + LEN_W'(1);
         end

         if (accept && !enc_illegal) begin
            mem_valid <= 1'b1;
            mem_wdata <= enc_word;
         end else if (wr_hs) begin
            mem_valid <= 1'b0;
         end
      end
   end

`ifdef ENC_ILLEGAL_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else
         err <= accept && enc_illegal;
   end
`else
   assign err = 1'b0;
`endif

endmodule
